// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_pkg                                                                    |
// | Shared constants for the iterative multiplier: widths and FSM encodings.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter must hold N itself, hence N+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_step                                                                   |
// | One combinational shift-add iteration retiring BITS_PER_CYCLE bits.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        i_prod,
  input  logic [2*WIDTH-1:0]        i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_bits,
  output logic [2*WIDTH-1:0]        o_prod_next
);

  always_comb begin
    o_prod_next = i_prod;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i_bits[i]) begin
        o_prod_next = o_prod_next + (i_mcand << i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_unit                                                                   |
// | Fixed-latency iterative multiplier/accumulator (MUL/MLA/xMULL/xMLAL).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             IsSigned,
  input  logic             Long,
  input  logic             AccEn,
  input  logic [WIDTH-1:0] AccLo,
  input  logic [WIDTH-1:0] AccHi,
  input  logic             HiSel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] Result
);

  localparam int             N   = WIDTH / BITS_PER_CYCLE;
  localparam int             CW  = cnt_width(N);
  localparam logic [CW-1:0]  C_N = CW'(N);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic               r_acc_en;
  logic [WIDTH-1:0]   r_res_lo;
  logic [WIDTH-1:0]   r_res_hi;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_launch;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [2*WIDTH-1:0] w_final;

  assign w_signed = IsSigned & Long;
  // The most-negative operand negates to itself, which reads correctly as unsigned 2^(W-1).
  assign w_abs_a  = (w_signed && SrcA[WIDTH-1]) ? (~SrcA + 1'b1) : SrcA;
  assign w_abs_b  = (w_signed && SrcB[WIDTH-1]) ? (~SrcB + 1'b1) : SrcB;
  assign w_launch = Start && ((r_state == IDLE) || (r_state == DONE));

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_prod      (r_prod),
    .i_mcand     (r_mcand),
    .i_bits      (r_mplier[BITS_PER_CYCLE-1:0]),
    .o_prod_next (w_prod_next)
  );

  always_comb begin
    w_final = r_neg ? (~w_prod_next + 1'b1) : w_prod_next;
    if (r_acc_en) begin
      w_final = w_final + r_acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_acc_en <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_res_lo <= w_final[WIDTH-1:0];
            r_res_hi <= w_final[2*WIDTH-1:WIDTH];
            r_state  <= DONE;
          end
        end
        IDLE, DONE: begin
          if (w_launch) begin
            r_state  <= RUN;
            r_cnt    <= C_N;
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_prod   <= '0;
            r_neg    <= w_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            r_acc_en <= AccEn;
            r_acc    <= {(Long ? AccHi : {WIDTH{1'b0}}), AccLo};
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy     = (r_state == RUN);
  assign Done     = (r_state == DONE);
  assign ResultLo = r_res_lo;
  assign ResultHi = r_res_hi;
  assign Result   = HiSel ? r_res_hi : r_res_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_unit                                                                |
// | Directed, table-driven self-checking bench for mul_unit.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] SrcA, SrcB, AccLo, AccHi;
  logic        IsSigned, Long, AccEn, HiSel;
  logic        Busy, Done;
  logic [31:0] ResultLo, ResultHi, Result;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_bd     = 0;

  always #5 clk = ~clk;

  mul_unit dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .IsSigned (IsSigned),
    .Long     (Long),
    .AccEn    (AccEn),
    .AccLo    (AccLo),
    .AccHi    (AccHi),
    .HiSel    (HiSel),
    .Busy     (Busy),
    .Done     (Done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi),
    .Result   (Result)
  );

  always @(negedge clk) begin
    if (Done) n_done++;
    if (Busy && Done) n_bd++;
  end

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        sgn, lng, acc_en;
    logic [31:0] acc_lo, acc_hi;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    SrcA = v.a; SrcB = v.b; IsSigned = v.sgn; Long = v.lng;
    AccEn = v.acc_en; AccLo = v.acc_lo; AccHi = v.acc_hi;
  endtask

  // Leaves the bench at the falling edge right after the launch edge.
  task automatic start_op(input vec_t v);
    @(negedge clk);
    drive(v);
    Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (Done) break;
    end
    if (!Done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no Done, expected Done within 100 cycles");
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic l, input logic e,
                              input logic [31:0] lo, input logic [31:0] hi, input logic [63:0] x);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.sgn = s; v.lng = l; v.acc_en = e;
    v.acc_lo = lo; v.acc_hi = hi; v.exp = x;
    return v;
  endfunction

  initial begin
    int   cyc;
    int   d0;
    vec_t v;

    vecs[0]  = mk("umull_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 64'hFFFFFFFE_00000001);
    vecs[1]  = mk("smull_m2x3",  32'hFFFFFFFE, 32'd3,        1, 1, 0, 0, 0, 64'hFFFFFFFF_FFFFFFFA);
    vecs[2]  = mk("umull_m2x3",  32'hFFFFFFFE, 32'd3,        0, 1, 0, 0, 0, 64'h00000002_FFFFFFFA);
    vecs[3]  = mk("smull_min",   32'h80000000, 32'h80000000, 1, 1, 0, 0, 0, 64'h40000000_00000000);
    vecs[4]  = mk("mla_7x6",     32'd7,        32'd6,        0, 0, 1, 32'd100, 0, 64'h00000000_0000008E);
    vecs[5]  = mk("smlal_m1",    32'hFFFFFFFF, 32'd1,        1, 1, 1, 32'd0, 32'd1, 64'h00000000_FFFFFFFF);
    vecs[6]  = mk("zero_op",     32'd0,        32'd12345,    0, 1, 0, 0, 0, 64'h0);
    vecs[7]  = mk("mul_sgn_ign", 32'hFFFFFFFE, 32'd3,        1, 0, 0, 0, 0, 64'h00000002_FFFFFFFA);
    vecs[8]  = mk("umlal",       32'h00010000, 32'h00010000, 0, 1, 1, 32'hFFFFFFFF, 32'd5, 64'h00000006_FFFFFFFF);
    vecs[9]  = mk("mla_hi_ign",  32'd2,        32'd3,        0, 0, 1, 32'd1, 32'hDEAD, 64'h00000000_00000007);
    vecs[10] = mk("smull_negneg",32'hFFFFFFFD, 32'hFFFFFFFB, 1, 1, 0, 0, 0, 64'h00000000_0000000F);
    vecs[11] = mk("smull_7xm2",  32'd7,        32'hFFFFFFFE, 1, 1, 0, 0, 0, 64'hFFFFFFFF_FFFFFFF2);

    reset = 1'b1; Start = 1'b0; HiSel = 1'b0;
    SrcA = '0; SrcB = '0; IsSigned = 0; Long = 0; AccEn = 0; AccLo = '0; AccHi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy_done", {62'd0, Busy, Done}, 64'd0);
    check("reset_results",   {ResultHi, ResultLo}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i]);
      wait_done(cyc);
      check({vecs[i].name, "_latency"}, 64'(cyc), 64'd32);
      check({vecs[i].name, "_lo"}, {32'd0, ResultLo}, {32'd0, vecs[i].exp[31:0]});
      check({vecs[i].name, "_hi"}, {32'd0, ResultHi}, {32'd0, vecs[i].exp[63:32]});
    end

    // Result mux follows HiSel; last op left hi=FFFFFFFF, lo=FFFFFFF2.
    @(negedge clk);
    HiSel = 1'b1; #1;
    check("hisel_hi", {32'd0, Result}, 64'hFFFFFFFF);
    HiSel = 1'b0; #1;
    check("hisel_lo", {32'd0, Result}, 64'hFFFFFFF2);

    // Start pulsed mid-RUN must be ignored.
    d0 = n_done;
    start_op(mk("m", 32'd5, 32'd5, 0, 1, 0, 0, 0, 0));
    repeat (8) @(posedge clk);
    @(negedge clk);
    SrcA = 32'd99; SrcB = 32'd99; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(cyc);
    check("midrun_result", {ResultHi, ResultLo}, 64'd25);
    repeat (3) @(negedge clk);
    check("midrun_one_done", 64'(n_done - d0), 64'd1);
    check("midrun_idle", {62'd0, Busy, Done}, 64'd0);

    // Back-to-back: Start held through DONE relaunches with no IDLE cycle.
    @(negedge clk);
    drive(mk("b1", 32'd3, 32'd4, 0, 1, 0, 0, 0, 0));
    Start = 1'b1;
    wait_done(cyc);
    check("b2b_first", {ResultHi, ResultLo}, 64'd12);
    @(negedge clk);
    SrcA = 32'd6; SrcB = 32'd7;
    @(posedge clk);
    #1;
    check("b2b_busy_no_idle", {63'd0, Busy}, 64'd1);
    check("b2b_result_held", {32'd0, ResultLo}, 64'd12);
    @(negedge clk);
    Start = 1'b0;
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'd32);
    check("b2b_second", {ResultHi, ResultLo}, 64'd42);

    // Asynchronous reset in the middle of RUN.
    start_op(mk("r", 32'd11, 32'd13, 0, 1, 0, 0, 0, 0));
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy_done", {62'd0, Busy, Done}, 64'd0);
    check("rst_mid_results", {ResultHi, ResultLo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    d0 = n_done;
    repeat (40) @(negedge clk);
    check("rst_mid_no_done", 64'(n_done - d0), 64'd0);
    v = mk("after_rst", 32'd9, 32'd9, 0, 1, 0, 0, 0, 64'd81);
    start_op(v);
    wait_done(cyc);
    check("after_rst_latency", 64'(cyc), 64'd32);
    check("after_rst_result", {ResultHi, ResultLo}, v.exp);

    repeat (2) @(negedge clk);
    check("busy_done_exclusive", 64'(n_bd), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
